// File: rtl/branch_pc_sequencer_pkg.sv
// Shared widths, fetch constants and the sequencer state type for the
// instruction-address path.
package riscv_pkg;

  localparam int unsigned RISC_V_DATA_WIDTH         = 32;
  localparam int unsigned INST_MEMORY_ADDRESS_WIDTH = 16;
  localparam int unsigned INST_BYTES                = 4;
  localparam int unsigned ALIGN_BITS                = $clog2(INST_BYTES);

  localparam logic [INST_MEMORY_ADDRESS_WIDTH-1:0] RESET_PC = 16'h0000;
  localparam logic [INST_MEMORY_ADDRESS_WIDTH-1:0] TRAP_PC  = 16'h0100;
  localparam logic [INST_MEMORY_ADDRESS_WIDTH-1:0] PC_STEP  =
    INST_MEMORY_ADDRESS_WIDTH'(INST_BYTES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    BR_CALC = 2'd2
  } pcseq_state_t;

endpackage

// File: rtl/branch_pc_sequencer_if.sv
// Execute/fetch-side signal bundle of the PC sequencer; the slave modport is
// the sequencer itself, the master modport is whoever drives it.
interface branch_pc_sequencer_if;
  import riscv_pkg::*;

  logic                                 start;
  logic                                 halt;
  logic                                 stall;
  logic                                 imem_gnt;
  logic                                 br_valid;
  logic                                 br_taken;
  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] br_pc;
  logic signed [RISC_V_DATA_WIDTH-1:0]  br_offset;
  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] pc;
  logic                                 imem_req;
  logic                                 flush;
  logic                                 redirect_busy;
  logic                                 misalign_err;

  modport master (
    output start, halt, stall, imem_gnt, br_valid, br_taken, br_pc, br_offset,
    input  pc, imem_req, flush, redirect_busy, misalign_err
  );

  modport slave (
    input  start, halt, stall, imem_gnt, br_valid, br_taken, br_pc, br_offset,
    output pc, imem_req, flush, redirect_busy, misalign_err
  );

endinterface

// File: rtl/branch_pc_sequencer_target.sv
// Registered branch-target stage: base + (offset << 1) with an alignment flag,
// captured on the cycle a taken branch is accepted.
module branch_target_calc
  import riscv_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load,
  input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] br_pc,
  input  logic signed [RISC_V_DATA_WIDTH-1:0]  br_offset,
  output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] target,
  output logic                                 aligned
);

  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] target_p1;
  logic                                 aligned_p1;
  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] target_p0;

  // Sum is formed at full data width so negative offsets wrap in the address space.
  function automatic logic [INST_MEMORY_ADDRESS_WIDTH-1:0] calc_target(
    input logic [INST_MEMORY_ADDRESS_WIDTH-1:0] base,
    input logic signed [RISC_V_DATA_WIDTH-1:0]  offset
  );
    logic signed [RISC_V_DATA_WIDTH-1:0] base_ext;
    logic signed [RISC_V_DATA_WIDTH-1:0] sum;
    base_ext = $signed(RISC_V_DATA_WIDTH'(base));
    sum      = base_ext + (offset <<< 1);
    return INST_MEMORY_ADDRESS_WIDTH'(sum);
  endfunction

  function automatic logic is_aligned(
    input logic [INST_MEMORY_ADDRESS_WIDTH-1:0] addr
  );
    return addr[ALIGN_BITS-1:0] == '0;
  endfunction

  assign target_p0 = calc_target(br_pc, br_offset);

  // p0 -> p1: operands captured with the branch; reset discards a pending target
  always_ff @(posedge clk) begin
    if (rst) begin
      target_p1  <= '0;
      aligned_p1 <= 1'b0;
    end else if (load) begin
      target_p1  <= target_p0;
      aligned_p1 <= is_aligned(target_p0);
    end
  end

  assign target  = target_p1;
  assign aligned = aligned_p1;

endmodule

// File: rtl/branch_pc_sequencer.sv
// Fetch PC owner: sequential advance on granted fetches, one-cycle registered
// redirect for taken branches, trap redirect on misaligned targets.
module branch_pc_sequencer
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  branch_pc_sequencer_if.slave  bus
);

  pcseq_state_t                         state_q, state_d;
  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                                 flush_q, flush_d;
  logic                                 misalign_q, misalign_d;
  logic                                 tgt_load;
  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] tgt_addr;
  logic                                 tgt_aligned;

  branch_target_calc u_target (
    .clk       (clk),
    .rst       (rst),
    .load      (tgt_load),
    .br_pc     (bus.br_pc),
    .br_offset (bus.br_offset),
    .target    (tgt_addr),
    .aligned   (tgt_aligned)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    tgt_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.halt) begin
          state_d = IDLE;
          pc_d    = RESET_PC;
        end else if (bus.br_valid && bus.br_taken) begin
          // A grant arriving with the branch is dropped: the redirect owns the PC.
          state_d  = BR_CALC;
          flush_d  = 1'b1;
          tgt_load = 1'b1;
        end else if (bus.imem_gnt && !bus.stall) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      BR_CALC: begin
        if (bus.halt) begin
          state_d = IDLE;
          pc_d    = RESET_PC;
        end else if (tgt_aligned) begin
          state_d = RUN;
          pc_d    = tgt_addr;
        end else begin
          state_d    = RUN;
          pc_d       = TRAP_PC;
          misalign_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // state/pc/pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.imem_req      = (state_q == RUN);
  assign bus.redirect_busy = (state_q == BR_CALC);
  assign bus.flush         = flush_q;
  assign bus.misalign_err  = misalign_q;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Bench for branch_pc_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_branch_pc_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Behavioural model: mode 0 = idle, 1 = fetching, 2 = computing redirect
  int   m_mode;
  int   m_pc;
  int   m_tgt;
  bit   m_flush;
  bit   m_mis;

  branch_pc_sequencer_if bus ();

  branch_pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    longint t;
    bit     nflush;
    bit     nmis;
    nflush = 0;
    nmis   = 0;
    if (rst) begin
      m_mode = 0;
      m_pc   = 0;
      m_tgt  = 0;
    end else begin
      case (m_mode)
        0: if (bus.start) m_mode = 1;
        1: begin
          if (bus.halt) begin
            m_mode = 0;
            m_pc   = 0;
          end else if (bus.br_valid && bus.br_taken) begin
            t      = longint'(bus.br_pc) + 2 * longint'(bus.br_offset);
            m_tgt  = int'(t & 64'hFFFF);
            m_mode = 2;
            nflush = 1;
          end else if (bus.imem_gnt && !bus.stall) begin
            m_pc = (m_pc + 4) % 65536;
          end
        end
        default: begin
          if (bus.halt) begin
            m_mode = 0;
            m_pc   = 0;
          end else begin
            m_mode = 1;
            if (m_tgt % 4 == 0) m_pc = m_tgt;
            else begin
              m_pc = 'h100;
              nmis = 1;
            end
          end
        end
      endcase
    end
    m_flush = nflush;
    m_mis   = nmis;
  endtask

  task automatic compare_model();
    chk("pc",            bus.pc,            m_pc);
    chk("imem_req",      bus.imem_req,      m_mode == 1);
    chk("redirect_busy", bus.redirect_busy, m_mode == 2);
    chk("flush",         bus.flush,         m_flush);
    chk("misalign_err",  bus.misalign_err,  m_mis);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle_inputs();
    bus.start    = 0;
    bus.halt     = 0;
    bus.stall    = 0;
    bus.imem_gnt = 0;
    bus.br_valid = 0;
    bus.br_taken = 0;
    bus.br_pc    = '0;
    bus.br_offset = '0;
  endtask

  task automatic branch(input int bpc, input int off);
    bus.br_valid  = 1;
    bus.br_taken  = 1;
    bus.br_pc     = 16'(bpc);
    bus.br_offset = 32'(off);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_mode = 0; m_pc = 0; m_tgt = 0; m_flush = 0; m_mis = 0;
    rst = 1;
    idle_inputs();
    @(negedge clk);

    // Reset held two cycles
    tick();
    tick();
    chk("rst_pc", bus.pc, 0);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_busy", bus.redirect_busy, 0);

    // Start with grant every cycle
    rst = 0;
    bus.start = 1;
    bus.imem_gnt = 1;
    tick();
    bus.start = 0;
    chk("start_req", bus.imem_req, 1);
    chk("start_pc0", bus.pc, 'h0000);
    tick();
    chk("seq_pc4", bus.pc, 'h0004);
    tick();
    chk("seq_pc8", bus.pc, 'h0008);

    // Stall with grant holds the PC and keeps requesting
    bus.stall = 1;
    repeat (3) tick();
    chk("stall_pc", bus.pc, 'h0008);
    chk("stall_req", bus.imem_req, 1);
    bus.stall = 0;
    tick();
    chk("unstall_pc", bus.pc, 'h000C);

    // Taken branch with simultaneous grant: no increment, one-cycle redirect
    branch('h20, 8);
    tick();
    bus.br_valid = 0;
    chk("br_flush", bus.flush, 1);
    chk("br_busy", bus.redirect_busy, 1);
    chk("br_req_low", bus.imem_req, 0);
    chk("br_no_inc", bus.pc, 'h000C);
    tick();
    chk("br_target", bus.pc, 'h0030);
    chk("br_req_back", bus.imem_req, 1);
    chk("br_flush_end", bus.flush, 0);

    // Backward branch wrapping below zero
    branch('h4, -6);
    tick();
    bus.br_valid = 0;
    tick();
    chk("wrap_target", bus.pc, 'hFFF8);

    // Misaligned target goes to the trap vector
    branch('h10, 1);
    tick();
    bus.br_valid = 0;
    tick();
    chk("mis_pc", bus.pc, 'h0100);
    chk("mis_pulse", bus.misalign_err, 1);
    tick();
    chk("mis_pulse_end", bus.misalign_err, 0);

    // Reset during the redirect cycle discards the pending target
    branch('h40, 4);
    tick();
    bus.br_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("rstcalc_pc", bus.pc, 0);
    chk("rstcalc_req", bus.imem_req, 0);
    tick();
    chk("rstcalc_flush", bus.flush, 0);
    chk("rstcalc_mis", bus.misalign_err, 0);
    chk("rstcalc_pc2", bus.pc, 0);

    // Halt together with a taken branch
    bus.start = 1;
    tick();
    bus.start = 0;
    tick();
    bus.halt = 1;
    branch('h80, 2);
    tick();
    bus.halt = 0;
    bus.br_valid = 0;
    chk("halt_br_req", bus.imem_req, 0);
    chk("halt_br_busy", bus.redirect_busy, 0);
    chk("halt_br_pc", bus.pc, 0);

    // Halt during the redirect cycle
    bus.start = 1;
    tick();
    bus.start = 0;
    branch('h80, 2);
    tick();
    bus.br_valid = 0;
    bus.halt = 1;
    tick();
    bus.halt = 0;
    chk("halt_calc_pc", bus.pc, 0);
    chk("halt_calc_req", bus.imem_req, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(99) == 0);
      bus.start    = ($urandom_range(3) == 0);
      bus.halt     = bus.start ? 1'b0 : ($urandom_range(29) == 0);
      bus.stall    = ($urandom_range(3) == 0);
      bus.imem_gnt = ($urandom_range(3) != 0);
      bus.br_valid = ($urandom_range(4) == 0);
      bus.br_taken = ($urandom_range(1) == 0);
      bus.br_pc    = 16'($urandom);
      if ($urandom_range(2) == 0) bus.br_pc[1:0] = 2'b00;
      case ($urandom_range(2))
        0: bus.br_offset = 32'($signed($urandom_range(64)) - 32);
        1: bus.br_offset = 32'(($signed($urandom_range(2000)) - 1000) * 2);
        default: bus.br_offset = 32'($urandom);
      endcase
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_pc_sequencer.md
Name: branch_pc_sequencer

Overview:
Owns the fetch PC and sequences the instruction-address path. Each granted fetch advances the PC sequentially. Taken branches from execute are redirected through a one-cycle registered target computation: target = branch_pc + (offset << 1). Sits between execute (branch resolution) and instruction memory (fetch request/grant).

Parameters:
RISC_V_DATA_WIDTH, 32, width of signed branch offset
INST_MEMORY_ADDRESS_WIDTH, 16, width of PC / instruction address
RESET_PC, 'h0000, PC loaded on reset and on halt
INST_BYTES, 4, sequential PC increment per granted fetch
TRAP_PC, 'h0100, PC loaded on misaligned branch target

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  leave IDLE, begin fetching
halt  in  1  return to IDLE, PC <- RESET_PC
stall  in  1  hold PC in RUN (pipeline back-pressure)
imem_gnt  in  1  instruction memory accepted current imem_req
br_valid  in  1  execute presents a resolved branch this cycle
br_taken  in  1  qualified by br_valid
br_pc  in  INST_MEMORY_ADDRESS_WIDTH  PC of the branch instruction
br_offset  in  RISC_V_DATA_WIDTH  signed offset, halfword units
pc  out  INST_MEMORY_ADDRESS_WIDTH  current fetch address
imem_req  out  1  fetch request at pc
flush  out  1  one-cycle pulse: kill younger in-flight instructions
redirect_busy  out  1  high while in BR_CALC
misalign_err  out  1  one-cycle pulse: target not INST_BYTES-aligned

Behaviour:
- Reset (rst=1 at posedge, overrides all inputs, any state): state=IDLE, pc=RESET_PC, imem_req=0, flush=0, redirect_busy=0, misalign_err=0. Latched branch operands are cleared, so a reset mid-redirect discards the pending target.
- imem_req is a Moore output, =1 only in RUN. flush and misalign_err are registered pulses, each exactly one cycle.
- IDLE: pc held. start -> RUN next cycle. br_valid is ignored.
- RUN:
  - Priority: halt > taken branch > sequential advance.
  - halt: -> IDLE, pc <= RESET_PC.
  - br_valid & br_taken: latch br_pc/br_offset, -> BR_CALC, flush=1 next cycle. A simultaneous imem_gnt is ignored for PC advance: no increment.
  - br_valid & !br_taken: no effect.
  - Otherwise, imem_gnt & !stall: pc <= pc + INST_BYTES, wrapping modulo 2^INST_MEMORY_ADDRESS_WIDTH.
  - imem_gnt & stall: pc held; the request repeats.
- BR_CALC (exactly 1 cycle, imem_req=0, redirect_busy=1):
  - Registered target computed from latched operands. offset is sign-extended, shifted left 1, added to zero-extended br_pc in RISC_V_DATA_WIDTH, then truncated to INST_MEMORY_ADDRESS_WIDTH. Negative offsets wrap.
  - Aligned target (target % INST_BYTES == 0): pc <= target, -> RUN.
  - Misaligned target: pc <= TRAP_PC, misalign_err=1 next cycle, -> RUN.
  - stall and br_valid are ignored in BR_CALC.
  - halt in BR_CALC: -> IDLE, pc <= RESET_PC; the target is dropped.
- Branch-to-redirect latency: fetch at target begins 2 cycles after br_valid is sampled.

Decomposition:
- Shared package (riscv_pkg): RISC_V_DATA_WIDTH, INST_MEMORY_ADDRESS_WIDTH, INST_BYTES, RESET_PC, TRAP_PC, and the state enum pcseq_state_t {IDLE, RUN, BR_CALC}.
- One sub-module, branch_target_calc: registered sign-extend/shift/add plus alignment flag, with synchronous reset. The FSM, PC register and output pulses stay in the top.

Test Plan:
- Reset/start: rst 2 cycles, start=1, imem_gnt=1 every cycle -> pc 0x0000, 0x0004, 0x0008, 0x000C; imem_req=1 from the cycle after start.
- Stall: pc=0x0008, stall=1 for 3 cycles with gnt=1 -> pc stays 0x0008, imem_req stays 1; releases to 0x000C.
- Taken branch: br_pc=0x0020, br_offset=+8, taken -> flush pulse, redirect_busy 1 cycle, pc=0x0030; imem_req low exactly 1 cycle.
- Backward branch with wrap: br_pc=0x0004, br_offset=-6 -> target 0xFFF8 (wraps in 16 bits), aligned, pc=0xFFF8.
- Misaligned target: br_pc=0x0010, br_offset=+1 -> target 0x0012 -> pc=TRAP_PC 0x0100, misalign_err 1-cycle pulse.
- Simultaneous/abort cases:
  - br taken + imem_gnt same cycle -> no +4, redirect wins.
  - rst asserted during BR_CALC -> IDLE, pc=0x0000, no flush or misalign pulse afterwards.
  - halt+branch same cycle -> IDLE.
